shift_unit: RTL
===============

SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 Parameter DATAW, default 32, meaning datapath width; SHALL be a power of two, at least 16.
REQ-002 Parameter SHAMTW, default $clog2(DATAW), meaning internal shift-amount width.
REQ-003 Port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1, meaning reset; asynchronous and active-low.
REQ-005 Port in_valid / in_ready, input / output, 1 / 1, meaning request handshake; a transfer occurs when both are high on a clock edge.
REQ-006 Port optype, input, OP_TYPE_W, meaning operation class.
REQ-007 Port operand, input, SHIFTER_OPERAND_W (12), meaning the raw shifter operand field.
REQ-008 Port rm_data, input, DATAW, meaning the Rm value, sampled with the request.
REQ-009 Port carry_in, input, 1, meaning the C flag, sampled with the request.
REQ-010 Port rs_addr / rs_en, output, REGAW / 1, meaning the Rs read request (rs_addr = operand[11:8]).
REQ-011 Port rs_data, input, DATAW, meaning read data, valid the cycle after rs_en.
REQ-012 Port out_valid / out_ready, output / input, 1 / 1, meaning the result handshake.
REQ-013 Port result, output, DATAW, meaning the shifted operand.
REQ-014 Port carry_out, output, 1, meaning the shifter carry.

Function
REQ-015 Operand layout SHALL be: [3:0] rm; [4] register-shift flag; [6:5] shiftcode (LSL=0, LSR=1, ASR=2, ROR=3); [11:7] imm5; [11:8] rot4 or rs; [7:0] imm8.
REQ-016 The FSM SHALL have states IDLE and RS_WAIT; in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-017 For OP_DATA_SHIFT with bit4=0, OP_DATA_ROR, OP_LDSTR_IMM and OP_LDSTR_REG, the result SHALL be registered with out_valid high 1 cycle after acceptance.
REQ-018 For OP_DATA_SHIFT with bit4=1 (shift by register), acceptance SHALL assert rs_en for one cycle and enter RS_WAIT.
REQ-019 On the next edge from RS_WAIT the block SHALL compute using rs_data[7:0], set out_valid, and return to IDLE; result latency is 2 cycles.
REQ-020 Immediate shift: LSL #0 SHALL pass Rm with carry=carry_in.
REQ-021 Immediate shift: LSR #0 and ASR #0 SHALL mean a shift by DATAW.
REQ-022 Immediate shift: ROR #0 SHALL mean RRX, giving {carry_in, rm[DATAW-1:1]} with carry=rm[0].
REQ-023 Register shift, amount 0: SHALL pass Rm with carry=carry_in.
REQ-024 Register shift, LSL/LSR: amount==DATAW SHALL give 0 with carry = rm[0] / rm[DATAW-1]; amount>DATAW SHALL give 0 with carry 0.
REQ-025 Register shift, ASR: amount>=DATAW SHALL give all bits equal to the sign bit, with carry = sign.
REQ-026 Register shift, ROR: rotate by amount mod DATAW; if amount!=0 and amount mod DATAW==0, result SHALL be Rm with carry=rm[DATAW-1].
REQ-027 OP_DATA_ROR SHALL give zero-extended imm8 rotated right by 2*rot4; carry = carry_in if rot4==0, else result[DATAW-1].
REQ-028 OP_LDSTR_IMM SHALL give the zero-extended 12-bit operand with carry=carry_in.
REQ-029 OP_LDSTR_REG SHALL use the immediate-shift rules on rm_data.
REQ-030 Any other optype SHALL give result 0 with carry=carry_in, latency 1.
REQ-031 Otherwise, for an in-range shift, carry SHALL be the last bit shifted out.
REQ-032 While out_valid && !out_ready, result, carry_out and out_valid SHALL hold stable.
REQ-033 Output accepted and new request accepted on the same edge: the old result SHALL retire and the new one SHALL load, with no bubble.
REQ-034 Request and operand fields SHALL be captured at acceptance; later input changes SHALL not affect an in-flight operation.

Reset
REQ-035 Asserting reset_n low SHALL immediately force state=IDLE, out_valid=0, rs_en=0, result=0 and carry_out=0, including mid-RS_WAIT; the pending operation is discarded.
REQ-036 After reset_n deasserts, in_ready SHALL be high on the first cycle.

Structure
REQ-037 LSL/LSR/ASR/ROR codes, OP_* optypes and operand field start/width constants SHALL live in the shared defines package.
REQ-038 The combinational shift-plus-carry datapath SHALL be one sub-module, barrel_shift_core (parameter DATAW), instantiated once and shared by both latencies.

Verification
REQ-039 OP_DATA_ROR, imm8=0xFF, rot4=4, carry_in=0 -> result 0xFF000000, carry 1, out_valid after 1 cycle.
REQ-040 OP_DATA_SHIFT, ROR #0, rm=0x00000001, carry_in=1 -> result 0x80000000, carry 1 (RRX).
REQ-041 Register LSR, rm=0x80000000, rs_data=32 -> rs_en pulse, result 0, carry 1 at cycle 2; then rs_data=33 -> result 0, carry 0.
REQ-042 Register ASR, rm=0x80000000, rs_data=200 -> result 0xFFFFFFFF, carry 1.
REQ-043 out_ready held low 3 cycles with a result pending -> result stable and in_ready low; out_ready and in_valid both high -> back-to-back acceptance with no bubble.
REQ-044 reset_n low during RS_WAIT -> out_valid 0 immediately, no result emitted, in_ready high after release.

Source files
------------

// File: rtl/shift_unit_pkg.sv
// Shared definitions for the shifter-operand unit: shift codes, operation
// classes and operand field positions.
package shift_unit_pkg;

    localparam int OP_TYPE_W         = 3;
    localparam int SHIFTER_OPERAND_W = 12;
    localparam int REGAW             = 4;

    localparam logic [OP_TYPE_W-1:0] OP_DATA_SHIFT = 3'd0;
    localparam logic [OP_TYPE_W-1:0] OP_DATA_ROR   = 3'd1;
    localparam logic [OP_TYPE_W-1:0] OP_LDSTR_IMM  = 3'd2;
    localparam logic [OP_TYPE_W-1:0] OP_LDSTR_REG  = 3'd3;

    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shcode_e;

    localparam int OPF_RM_LSB    = 0;
    localparam int OPF_RM_W      = 4;
    localparam int OPF_REGSH_BIT = 4;
    localparam int OPF_SHC_LSB   = 5;
    localparam int OPF_SHC_W     = 2;
    localparam int OPF_IMM5_LSB  = 7;
    localparam int OPF_IMM5_W    = 5;
    localparam int OPF_ROT_LSB   = 8;
    localparam int OPF_ROT_W     = 4;
    localparam int OPF_IMM8_LSB  = 0;
    localparam int OPF_IMM8_W    = 8;

    // Shift amounts must hold both a full register byte and the value DATAW.
    function automatic int amt_width(input int dataw);
        int w;
        w = $clog2(dataw) + 1;
        return (w > 8) ? w : 8;
    endfunction

endpackage

// File: rtl/shift_unit_barrel_shift_core.sv
// Combinational barrel shifter with carry-out; the caller encodes immediate
// special cases as amount==DATAW or the rrx flag.
module barrel_shift_core
    import shift_unit_pkg::*;
#(
    parameter int DATAW = 32
) (
    input  logic [DATAW-1:0]            value,
    input  shcode_e                     shcode,
    input  logic [amt_width(DATAW)-1:0] amount,
    input  logic                        rrx,
    input  logic                        carry_in,
    output logic [DATAW-1:0]            result,
    output logic                        carry
);

    localparam int SHW  = $clog2(DATAW);
    localparam int AMTW = amt_width(DATAW);
    localparam logic [AMTW-1:0] DW_A = AMTW'(DATAW);

    logic [SHW-1:0]   amt_lo;
    logic [DATAW:0]   lsl_ext;
    logic [DATAW:0]   lsr_ext;
    logic [DATAW:0]   asr_ext;
    logic [DATAW-1:0] ror_res;

    assign amt_lo  = amount[SHW-1:0];
    // One guard bit on each side catches the last bit shifted out.
    assign lsl_ext = {1'b0, value} << amt_lo;
    assign lsr_ext = {value, 1'b0} >> amt_lo;
    assign asr_ext = $signed({value, 1'b0}) >>> amt_lo;
    assign ror_res = DATAW'({value, value} >> amt_lo);

    always_comb begin
        result = value;
        carry  = carry_in;
        if (rrx) begin
            result = {carry_in, value[DATAW-1:1]};
            carry  = value[0];
        end else if (amount != '0) begin
            case (shcode)
                SH_LSL: begin
                    if (amount < DW_A) begin
                        {carry, result} = lsl_ext;
                    end else begin
                        result = '0;
                        carry  = (amount == DW_A) ? value[0] : 1'b0;
                    end
                end
                SH_LSR: begin
                    if (amount < DW_A) begin
                        {result, carry} = lsr_ext;
                    end else begin
                        result = '0;
                        carry  = (amount == DW_A) ? value[DATAW-1] : 1'b0;
                    end
                end
                SH_ASR: begin
                    if (amount < DW_A) begin
                        {result, carry} = asr_ext;
                    end else begin
                        result = {DATAW{value[DATAW-1]}};
                        carry  = value[DATAW-1];
                    end
                end
                default: begin
                    result = ror_res;
                    carry  = ror_res[DATAW-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_unit.sv
// Shifter-operand unit: decodes the 12-bit operand, optionally fetches Rs,
// and returns the shifted value and carry over a valid/ready handshake.
//
//   state   | meaning
//   IDLE    | ready for a request; immediate forms resolve on acceptance
//   RS_WAIT | Rs read in flight; result computed from rs_data on next edge
module shift_unit
    import shift_unit_pkg::*;
#(
    parameter int DATAW  = 32,
    parameter int SHAMTW = $clog2(DATAW)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OP_TYPE_W-1:0]         optype,
    input  logic [SHIFTER_OPERAND_W-1:0] operand,
    input  logic [DATAW-1:0]             rm_data,
    input  logic                         carry_in,
    output logic [REGAW-1:0]             rs_addr,
    output logic                         rs_en,
    input  logic [DATAW-1:0]             rs_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATAW-1:0]             result,
    output logic                         carry_out
);

    localparam int AMTW = (SHAMTW + 1 > 8) ? SHAMTW + 1 : 8;

    typedef enum logic {IDLE, RS_WAIT} state_e;

    state_e                         state_q, state_d;
    logic [OP_TYPE_W-1:0]           op_q, op_s;
    logic [SHIFTER_OPERAND_W-1:0]   opr_q, opr_s;
    logic [DATAW-1:0]               rm_q, rm_s;
    logic                           cin_q, cin_s;
    logic                           accept, is_regsh, load;
    logic [OPF_IMM5_W-1:0]          imm5;
    shcode_e                        shc;
    logic [DATAW-1:0]               core_value, core_result;
    shcode_e                        core_code;
    logic [AMTW-1:0]                core_amt;
    logic                           core_rrx, core_carry;
    logic                           unused_bits;

    assign in_ready = (state_q == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_regsh = (optype == OP_DATA_SHIFT) && operand[OPF_REGSH_BIT];
    assign rs_en    = (state_q == RS_WAIT);
    assign rs_addr  = opr_q[OPF_ROT_LSB +: REGAW];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_regsh) begin
                        state_d = RS_WAIT;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            RS_WAIT: begin
                state_d = IDLE;
                load    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Live inputs feed the core on acceptance; captured copies while waiting on Rs.
    assign op_s  = (state_q == RS_WAIT) ? op_q  : optype;
    assign opr_s = (state_q == RS_WAIT) ? opr_q : operand;
    assign rm_s  = (state_q == RS_WAIT) ? rm_q  : rm_data;
    assign cin_s = (state_q == RS_WAIT) ? cin_q : carry_in;
    assign imm5  = opr_s[OPF_IMM5_LSB +: OPF_IMM5_W];
    assign shc   = shcode_e'(opr_s[OPF_SHC_LSB +: OPF_SHC_W]);

    always_comb begin
        core_value = rm_s;
        core_code  = shc;
        core_amt   = '0;
        core_rrx   = 1'b0;
        case (op_s)
            OP_DATA_SHIFT, OP_LDSTR_REG: begin
                if (op_s == OP_DATA_SHIFT && opr_s[OPF_REGSH_BIT]) begin
                    core_amt = AMTW'(rs_data[7:0]);
                end else if (imm5 != '0) begin
                    core_amt = AMTW'(imm5);
                end else begin
                    case (shc)
                        SH_LSR, SH_ASR: core_amt = AMTW'(DATAW);
                        SH_ROR:         core_rrx = 1'b1;
                        default:        core_amt = '0;
                    endcase
                end
            end
            OP_DATA_ROR: begin
                core_value = DATAW'(opr_s[OPF_IMM8_LSB +: OPF_IMM8_W]);
                core_code  = SH_ROR;
                core_amt   = AMTW'({opr_s[OPF_ROT_LSB +: OPF_ROT_W], 1'b0});
            end
            OP_LDSTR_IMM: begin
                core_value = DATAW'(opr_s);
                core_code  = SH_LSL;
            end
            default: begin
                core_value = '0;
                core_code  = SH_LSL;
            end
        endcase
    end

    barrel_shift_core #(.DATAW(DATAW)) u_core (
        .value    (core_value),
        .shcode   (core_code),
        .amount   (core_amt),
        .rrx      (core_rrx),
        .carry_in (cin_s),
        .result   (core_result),
        .carry    (core_carry)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q      <= '0;
            opr_q     <= '0;
            rm_q      <= '0;
            cin_q     <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= optype;
                opr_q <= operand;
                rm_q  <= rm_data;
                cin_q <= carry_in;
            end
            if (load) begin
                out_valid <= 1'b1;
                result    <= core_result;
                carry_out <= core_carry;
            end else if (out_ready || accept) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign unused_bits = ^{rs_data[DATAW-1:8], opr_s[OPF_RM_LSB +: OPF_RM_W]};

endmodule
